// File: rtl/point_add_seq.sv
// ---------------------------------------------------------------------------
// point_add_seq
//
// Sequencer for one affine elliptic-curve point addition P3 = P1 + P2.
// The block does no field arithmetic. It drives a shared external ALU
// (SUB / MUL / INV modulo p) through a fixed ten-step program and keeps
// the intermediate values in W-bit registers.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset
//   start      : request one addition (accepted only while idle)
//   x1,y1,x2,y2: affine operands, latched on the accepted start edge
//   busy       : high from the accepting edge until the cycle after done
//   done       : one-cycle completion pulse
//   err        : x1 == x2 detected (valid with done, held afterwards)
//   x3,y3      : result coordinates, held until next completion or reset
//   alu_req    : ALU request, high only while an op is outstanding
//   alu_op     : 0 = SUB, 1 = MUL, 2 = INV
//   alu_a/b    : ALU operands, stable while alu_req is high
//   alu_ack    : ALU completion (may arrive in the first request cycle)
//   alu_result : ALU result, sampled on the edge where req and ack are high
// ---------------------------------------------------------------------------
module point_add_seq #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] y2,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] x3,
    output logic [W-1:0] y3,
    output logic         alu_req,
    output logic [1:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic         alu_ack,
    input  logic [W-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_PREP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_SUB    = 2'd0;
    localparam logic [1:0] OP_MUL    = 2'd1;
    localparam logic [1:0] OP_INV    = 2'd2;
    localparam logic [3:0] STEP_DX   = 4'd1;
    localparam logic [3:0] STEP_LAST = 4'd9;

    state_t       r_state;
    logic [3:0]   r_step;

    // latched operands
    logic [W-1:0] r_x1, r_y1, r_x2, r_y2;

    // intermediates of the addition program
    logic [W-1:0] r_t0, r_t1, r_lam, r_t2, r_t3, r_x3r, r_y3r;

    // registered outputs
    logic [W-1:0] r_x3, r_y3;
    logic         r_busy, r_done, r_err;
    logic         r_alu_req;
    logic [1:0]   r_alu_op;
    logic [W-1:0] r_alu_a, r_alu_b;

    logic [1:0]   w_nxt_op;
    logic [W-1:0] w_nxt_a, w_nxt_b;
    logic         w_ack;
    logic         w_dx_zero;

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign x3      = r_x3;
    assign y3      = r_y3;
    assign alu_req = r_alu_req;
    assign alu_op  = r_alu_op;
    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;

    // An ack only counts while a request is outstanding.
    assign w_ack     = r_alu_req & alu_ack;
    // x2 - x1 == 0 means the slope is undefined (doubling or P2 = -P1).
    assign w_dx_zero = (r_step == STEP_DX) && (alu_result == '0);

    // Operand selection for the op about to be issued from PREP. The step
    // counter has already advanced and the previous result is registered,
    // so everything here comes straight from registers. Step 0 is issued
    // from IDLE using the input ports directly.
    always_comb begin
        w_nxt_op = OP_SUB;
        w_nxt_a  = '0;
        w_nxt_b  = '0;
        case (r_step)
            4'd1: begin w_nxt_op = OP_SUB; w_nxt_a = r_x2;  w_nxt_b = r_x1;  end
            4'd2: begin w_nxt_op = OP_INV; w_nxt_a = r_t1;  w_nxt_b = '0;    end
            4'd3: begin w_nxt_op = OP_MUL; w_nxt_a = r_t0;  w_nxt_b = r_t1;  end
            4'd4: begin w_nxt_op = OP_MUL; w_nxt_a = r_lam; w_nxt_b = r_lam; end
            4'd5: begin w_nxt_op = OP_SUB; w_nxt_a = r_t2;  w_nxt_b = r_x1;  end
            4'd6: begin w_nxt_op = OP_SUB; w_nxt_a = r_t2;  w_nxt_b = r_x2;  end
            4'd7: begin w_nxt_op = OP_SUB; w_nxt_a = r_x1;  w_nxt_b = r_x3r; end
            4'd8: begin w_nxt_op = OP_MUL; w_nxt_a = r_lam; w_nxt_b = r_t3;  end
            4'd9: begin w_nxt_op = OP_SUB; w_nxt_a = r_t3;  w_nxt_b = r_y1;  end
            default: begin
                w_nxt_op = OP_SUB;
                w_nxt_a  = '0;
                w_nxt_b  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_step    <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_x2      <= '0;
            r_y2      <= '0;
            r_t0      <= '0;
            r_t1      <= '0;
            r_lam     <= '0;
            r_t2      <= '0;
            r_t3      <= '0;
            r_x3r     <= '0;
            r_y3r     <= '0;
            r_x3      <= '0;
            r_y3      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_alu_req <= 1'b0;
            r_alu_op  <= OP_SUB;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x1      <= x1;
                        r_y1      <= y1;
                        r_x2      <= x2;
                        r_y2      <= y2;
                        r_step    <= '0;
                        r_busy    <= 1'b1;
                        r_alu_req <= 1'b1;
                        r_alu_op  <= OP_SUB;
                        r_alu_a   <= y2;
                        r_alu_b   <= y1;
                        r_state   <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (w_ack) begin
                        case (r_step)
                            4'd0:    r_t0  <= alu_result;
                            4'd1:    r_t1  <= alu_result;
                            4'd2:    r_t1  <= alu_result;
                            4'd3:    r_lam <= alu_result;
                            4'd4:    r_t2  <= alu_result;
                            4'd5:    r_t2  <= alu_result;
                            4'd6:    r_x3r <= alu_result;
                            4'd7:    r_t3  <= alu_result;
                            4'd8:    r_t3  <= alu_result;
                            4'd9:    r_y3r <= alu_result;
                            default: ;
                        endcase
                        r_step    <= r_step + 4'd1;
                        r_alu_req <= 1'b0;
                        r_alu_op  <= OP_SUB;
                        r_alu_a   <= '0;
                        r_alu_b   <= '0;
                        if (r_step == STEP_LAST) begin
                            // y3r is being written this same edge, so take
                            // the result straight from the ALU.
                            r_x3    <= r_x3r;
                            r_y3    <= alu_result;
                            r_err   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_dx_zero) begin
                            r_x3    <= '0;
                            r_y3    <= '0;
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_PREP;
                        end
                    end
                end

                S_PREP: begin
                    r_alu_req <= 1'b1;
                    r_alu_op  <= w_nxt_op;
                    r_alu_a   <= w_nxt_a;
                    r_alu_b   <= w_nxt_b;
                    r_state   <= S_EXEC;
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/point_add_seq.md
POINT_ADD_SEQ -- requirements
Module: point_add_seq

Interface
REQ-001 SHALL have parameter: W, 256, operand/coordinate width in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: start input 1 (pulse, request one point addition); x1, y1, x2, y2 input W (affine operands, sampled on accepted start).
REQ-005 SHALL have ports: busy output 1 (operation in progress); done output 1 (one-cycle completion pulse); err output 1 (x1==x2, valid with done).
REQ-006 SHALL have ports: x3, y3 output W (result coordinates, held until next completion or reset).
REQ-007 SHALL have shared-ALU ports: alu_req output 1; alu_op output 2 (0=SUB, 1=MUL, 2=INV); alu_a, alu_b output W; alu_ack input 1; alu_result input W.

Function
REQ-008 SHALL accept start only in IDLE; start while busy SHALL be ignored, with no effect on state or latched operands.
REQ-009 SHALL latch x1,y1,x2,y2 into internal registers on the accepted-start edge; later input changes SHALL NOT affect the operation.
REQ-010 SHALL implement states IDLE, EXEC, PREP, DONE; IDLE->EXEC on start; EXEC->PREP on alu_ack (op 0..8); EXEC->DONE on alu_ack of op 9 or on error; PREP->EXEC unconditionally; DONE->IDLE unconditionally.
REQ-011 SHALL issue exactly this op sequence (dst <- op a,b): 0 t0<-SUB y2,y1; 1 t1<-SUB x2,x1; 2 t1<-INV t1; 3 lam<-MUL t0,t1; 4 t2<-MUL lam,lam; 5 t2<-SUB t2,x1; 6 x3r<-SUB t2,x2; 7 t3<-SUB x1,x3r; 8 t3<-MUL lam,t3; 9 y3r<-SUB t3,y1.
REQ-012 SHALL assert alu_req only in EXEC, with alu_op/alu_a/alu_b stable and alu_req held high until the cycle alu_ack is seen high.
REQ-013 SHALL sample alu_result into the step's destination register on the clock edge where alu_req and alu_ack are both high; ack in the first req cycle SHALL be legal.
REQ-014 SHALL deassert alu_req for exactly one cycle (PREP) between consecutive ops; alu_ack while alu_req is low SHALL be ignored.
REQ-015 SHALL treat SUB as (a-b) mod p; the block performs no arithmetic itself, and internal result registers are W bits with no truncation.
REQ-016 SHALL, when op 1 result is zero, skip ops 2..9, enter DONE, and drive err=1 with x3=y3=0 for that completion.
REQ-017 SHALL, on normal completion, load x3<=x3r and y3<=y3r on entry to DONE and drive err=0.
REQ-018 SHALL assert done for exactly one cycle, in DONE; busy SHALL be 1 in EXEC, PREP, DONE and 0 in IDLE.
REQ-019 SHALL, with zero-wait ALU (ack in first req cycle) and start accepted at cycle 0, issue op k in cycle 1+2k and pulse done in cycle 20; each ALU wait cycle SHALL add exactly one cycle.
REQ-020 SHALL allow a new start in the cycle after DONE (IDLE); back-to-back operations SHALL be independent.
REQ-021 SHALL hold err at its last completion value until the next done pulse or reset.

Reset
REQ-022 SHALL, on rst high at any clock edge, go to IDLE and clear busy, done, err, alu_req, x3, y3, the step counter, and all internal registers to 0.
REQ-023 SHALL, on reset mid-operation, drop alu_req at the next edge, pulse no done, and ignore any pending alu_ack.
REQ-024 SHALL drive alu_op=0 and alu_a=alu_b=0 whenever alu_req is low.

Verification
REQ-025 SHALL pass: zero-wait ALU model, P1=(G), P2=(2G) on secp256k1 -> done at cycle 20, x3/y3 equal 3G, err=0.
REQ-026 SHALL pass: x1==x2 (P2=P1) -> exactly two ALU ops issued, done at cycle 4, err=1, x3=y3=0.
REQ-027 SHALL pass: ALU with 3 wait cycles per op -> done at cycle 50, same result as REQ-025, alu_a/alu_b stable during every wait.
REQ-028 SHALL pass: start pulsed again at cycles 5 and 20 -> both ignored; the cycle-21 start is accepted and runs normally.
REQ-029 SHALL pass: rst asserted during op 4 EXEC -> alu_req=0, busy=0, x3=y3=0 next cycle, no done pulse; a subsequent start completes correctly.
